axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
//   AXI4 subordinate (responder) that terminates the manager-side AXI bus driven by
//   cpu_subsystem (axi_req_t/axi_resp_t from core_v_mcu_axi_pkg) on a single-port SRAM.
//   One transaction in flight at a time; FIXED/INCR/WRAP bursts; responds OKAY/SLVERR.
//   Sits in core_v_mcu as the boot/data memory endpoint of the CPU bus.
// PARAMETERS
//   AddrWidth   64        AXI address width (bits)
//   DataWidth   64        AXI/SRAM data width (bits); power of two, >= 32
//   IdWidth     4         AXI ID width (bits)
//   NumWords    1024      SRAM depth in DataWidth words; power of two
//   axi_req_t   core_v_mcu_axi_pkg::axi_req_t    request struct type
//   axi_resp_t  core_v_mcu_axi_pkg::axi_resp_t   response struct type
// PORTS
//   clk_i        in   1                   clock; all logic on rising edge
//   rst_i        in   1                   reset, asynchronous, active-high
//   axi_req_i    in   axi_req_t           AW/W/AR channels + b_ready, r_ready
//   axi_resp_o   out  axi_resp_t          aw/w/ar_ready, B and R channels
//   mem_req_o    out  1                   SRAM access strobe (one access per cycle)
//   mem_we_o     out  1                   1 = write, 0 = read
//   mem_addr_o   out  $clog2(NumWords)    SRAM word index
//   mem_wdata_o  out  DataWidth           write data
//   mem_be_o     out  DataWidth/8         byte enables (= wstrb on writes, all-ones on reads)
//   mem_rdata_i  in   DataWidth           read data, valid exactly 1 cycle after mem_req_o && !mem_we_o
// BEHAVIOUR
//   Reset: state=IDLE; all ready/valid outputs and mem_req_o 0; rr_prio=READ; regs 0.
//   Reset asserted mid-burst aborts it: no further R/B beats, no SRAM access.
//   FSM: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
//   - IDLE: ar_ready=aw_ready=0 unless granted. Both ar_valid and aw_valid: grant rr_prio
//     side, toggle rr_prio. Else grant the valid one. Grant = ready high 1 cycle, capture
//     id/addr/len/size/burst; AR -> RD_REQ, AW -> WR_DATA.
//   - RD_REQ: mem_req_o=1, mem_we_o=0 (suppressed if beat out of range) -> RD_DATA.
//   - RD_DATA: r_valid=1; r_data=registered mem_rdata_i (0 if out of range), r_id=captured id,
//     r_resp=OKAY/SLVERR per beat, r_last=(beat==len). R stable until r_ready.
//     On handshake: last -> IDLE, else advance address -> RD_REQ.
//     Latency: AR handshake cycle N -> r_valid at N+2; max 1 beat per 2 cycles.
//   - WR_DATA: w_ready=1. On w_valid: mem_req_o=mem_we_o=1 same cycle (suppressed if out of
//     range), be=wstrb, advance address. w_last -> WR_RESP. w_last/len mismatch ignored;
//     beat count is driven by w_last.
//   - WR_RESP: b_valid=1, b_id=captured id, b_resp=SLVERR if any beat out of range else OKAY.
//     Hold until b_ready -> IDLE.
//   Address: word index = addr[$clog2(NumWords)+$clog2(DataWidth/8)-1 : $clog2(DataWidth/8)].
//     Out of range iff addr >= NumWords*DataWidth/8. Next addr by burst type:
//     FIXED unchanged; INCR += 2**size (no 4KiB check); WRAP wraps at (len+1)*2**size
//     aligned boundary. WRAP len not in {1,3,7,15} treated as INCR.
//   Narrow reads return the full SRAM word; lane selection is the manager's job.
//   len=0 single beat: R or B with last asserted on the first beat.
//   ar/aw_ready low outside IDLE; w_ready low outside WR_DATA (W never taken before AW).
//   Unsupported fields (lock, cache, prot, qos, region, atop, user) ignored; user outputs 0.
// TESTING
//   1 Write INCR addr 0x100, len=3, size=3, data 0xA0..A3, wstrb=0xFF -> 4 SRAM writes at idx
//     0x20..0x23, B OKAY with matching id.
//   2 Read back the same burst -> R beats 0xA0..A3, r_last on beat 4; first r_valid 2 cycles
//     after AR handshake.
//   3 AR and AW valid in the same cycle, twice after reset -> read granted first, write second.
//   4 WRAP read len=3, size=3 at 0x118 -> word idx 0x23,0x20,0x21,0x22.
//   5 Write at addr NumWords*8 with wstrb=0x0F -> no mem_req_o, B SLVERR; read -> r_data 0, SLVERR.
//   6 r_ready low 5 cycles mid-burst, then rst_i pulse -> R data stable while stalled;
//     after reset all valid/ready 0, state IDLE, no pending beats.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI4 responder terminating the CPU bus on a single-port SRAM, one transaction at a time.
// The channel types shared with cpu_subsystem live in the package below.
package core_v_mcu_axi_pkg;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_resp_t;
endpackage

module axi_sram_responder #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned NumWords  = 1024,
  parameter type axi_req_t  = core_v_mcu_axi_pkg::axi_req_t,
  parameter type axi_resp_t = core_v_mcu_axi_pkg::axi_resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  axi_req_t                    axi_req_i,
  output axi_resp_t                   axi_resp_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [$clog2(NumWords)-1:0] mem_addr_o,
  output logic [DataWidth-1:0]        mem_wdata_o,
  output logic [DataWidth/8-1:0]      mem_be_o,
  input  logic [DataWidth-1:0]        mem_rdata_i
);
  localparam int unsigned IdxWidth = $clog2(NumWords);
  localparam int unsigned OffWidth = $clog2(DataWidth / 8);
  localparam logic [AddrWidth-1:0] MemBytes = AddrWidth'(NumWords) * AddrWidth'(DataWidth / 8);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [2:0] {StIdle, StRdReq, StRdData, StWrData, StWrResp} state_e;

  state_e                 state_q, state_d;
  logic                   rr_write_q, rr_write_d;  // 0: a read wins the next AR/AW tie
  logic [IdWidth-1:0]     id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [7:0]             len_q, len_d, beat_q, beat_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic                   err_q, err_d;
  logic                   rd_fresh_q, rd_fresh_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;

  logic                   out_of_range, wrap_ok, grant_rd, grant_wr, r_last;
  logic [AddrWidth-1:0]   addr_inc, wrap_mask, addr_next;
  logic [DataWidth-1:0]   r_data;
  logic                   unused_fields;

  assign unused_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                           axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.atop,
                           axi_req_i.aw.user, axi_req_i.ar.lock, axi_req_i.ar.cache,
                           axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region,
                           axi_req_i.ar.user, axi_req_i.w.user};

  assign out_of_range = (addr_q >= MemBytes);
  assign r_last       = (beat_q == len_q);

  always_comb begin
    addr_inc  = addr_q + (AddrWidth'(1) << size_q);
    wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);
    if (burst_q == BurstFixed) begin
      addr_next = addr_q;
    end else if (burst_q == BurstWrap && wrap_ok) begin
      addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end else begin
      addr_next = addr_inc;  // INCR, reserved, and WRAP with an illegal length
    end
  end

  // The first RD_DATA cycle forwards the SRAM output; later stalled cycles replay the capture.
  assign r_data = out_of_range ? '0 : (rd_fresh_q ? mem_rdata_i : rdata_q);

  always_comb begin
    state_d     = state_q;
    rr_write_d  = rr_write_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_d       = err_q;
    rd_fresh_d  = 1'b0;
    rdata_d     = rdata_q;
    grant_rd    = 1'b0;
    grant_wr    = 1'b0;
    axi_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr_q[IdxWidth+OffWidth-1:OffWidth];
    mem_wdata_o = '0;
    mem_be_o    = '1;

    unique case (state_q)
      StIdle: begin
        if (!rst_i) begin
          grant_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !rr_write_q);
          grant_wr = axi_req_i.aw_valid && !grant_rd;
          if (axi_req_i.ar_valid && axi_req_i.aw_valid) rr_write_d = !rr_write_q;
        end
        if (grant_rd) begin
          axi_resp_o.ar_ready = 1'b1;
          id_d    = axi_req_i.ar.id;
          addr_d  = axi_req_i.ar.addr;
          len_d   = axi_req_i.ar.len;
          size_d  = axi_req_i.ar.size;
          burst_d = axi_req_i.ar.burst;
          beat_d  = '0;
          state_d = StRdReq;
        end else if (grant_wr) begin
          axi_resp_o.aw_ready = 1'b1;
          id_d    = axi_req_i.aw.id;
          addr_d  = axi_req_i.aw.addr;
          len_d   = axi_req_i.aw.len;
          size_d  = axi_req_i.aw.size;
          burst_d = axi_req_i.aw.burst;
          err_d   = 1'b0;
          state_d = StWrData;
        end
      end
      StRdReq: begin
        mem_req_o  = !out_of_range;
        rd_fresh_d = 1'b1;
        state_d    = StRdData;
      end
      StRdData: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = r_data;
        axi_resp_o.r.resp  = out_of_range ? RespSlvErr : RespOkay;
        axi_resp_o.r.last  = r_last;
        rdata_d            = r_data;
        if (axi_req_i.r_ready) begin
          if (r_last) begin
            state_d = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_next;
            state_d = StRdReq;
          end
        end
      end
      StWrData: begin
        axi_resp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          mem_req_o   = !out_of_range;
          mem_we_o    = 1'b1;
          mem_wdata_o = axi_req_i.w.data;
          mem_be_o    = axi_req_i.w.strb;
          err_d       = err_q | out_of_range;
          addr_d      = addr_next;
          if (axi_req_i.w.last) state_d = StWrResp;
        end
      end
      StWrResp: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = id_q;
        axi_resp_o.b.resp  = err_q ? RespSlvErr : RespOkay;
        if (axi_req_i.b_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_write_q <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      rd_fresh_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_write_q <= rr_write_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      rd_fresh_q <= rd_fresh_d;
      rdata_q    <= rdata_d;
    end
  end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: bursts, arbitration, wrap, range errors, stall and reset.
module tb_axi_sram_responder;
  import core_v_mcu_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  axi_req_t    req;
  axi_resp_t   resp;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int req_cnt = 0;
  logic [9:0]  wr_log[$];
  logic [9:0]  rd_log[$];
  logic [63:0] sram[1024];

  logic [63:0] rd_data[16];
  logic [1:0]  rd_resp[16];
  logic        rd_last[16];
  logic [3:0]  rd_id[16];
  int          r_first_cyc;

  axi_sram_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi_req_i  (req),
    .axi_resp_o (resp),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: byte-enabled writes, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      req_cnt++;
      if (mem_we) begin
        wr_log.push_back(mem_addr);
        for (int b = 0; b < 8; b++) if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        rd_log.push_back(mem_addr);
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present an AR (is_write=0) or AW (is_write=1); returns the handshake cycle or -1.
  task automatic addr_go(input bit is_write, input logic [3:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                         output int hs_cyc);
    int n = 0;
    @(negedge clk);
    if (is_write) begin
      req.aw = '0; req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
      req.aw.size = size; req.aw.burst = burst; req.aw_valid = 1'b1;
    end else begin
      req.ar = '0; req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
      req.ar.size = size; req.ar.burst = burst; req.ar_valid = 1'b1;
    end
    hs_cyc = -1;
    while (hs_cyc < 0 && n < 40) begin
      #1;
      if (is_write ? resp.aw_ready : resp.ar_ready) hs_cyc = cyc;
      @(negedge clk);
      n++;
    end
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    if (hs_cyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL addr_handshake: got timeout, required ready within 40 cycles");
    end
  endtask

  task automatic w_beats(input logic [63:0] base, input logic [7:0] strb, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      bit done = 1'b0;
      req.w = '0; req.w.data = base + 64'(i); req.w.strb = strb;
      req.w.last = (i == nbeats - 1); req.w_valid = 1'b1;
      while (!done && n < 40) begin
        #1;
        if (resp.w_ready) done = 1'b1;
        @(negedge clk);
        n++;
      end
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL w_handshake: got timeout on beat %0d, required w_ready", i);
        break;
      end
    end
    req.w_valid = 1'b0;
  endtask

  task automatic b_collect(output logic [3:0] id, output logic [1:0] rsp);
    int n = 0;
    bit got = 1'b0;
    id = 'x; rsp = 'x;
    req.b_ready = 1'b1;
    while (!got && n < 40) begin
      #1;
      if (resp.b_valid) begin got = 1'b1; id = resp.b.id; rsp = resp.b.resp; end
      @(negedge clk);
      n++;
    end
    req.b_ready = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL b_handshake: got timeout, required b_valid");
    end
  endtask

  task automatic r_collect(input int nbeats);
    int n = 0;
    int got = 0;
    r_first_cyc = -1;
    req.r_ready = 1'b1;
    while (got < nbeats && n < 100) begin
      #1;
      if (resp.r_valid) begin
        if (r_first_cyc < 0) r_first_cyc = cyc;
        rd_data[got] = resp.r.data; rd_resp[got] = resp.r.resp;
        rd_last[got] = resp.r.last; rd_id[got] = resp.r.id;
        got++;
      end
      @(negedge clk);
      n++;
    end
    req.r_ready = 1'b0;
    if (got < nbeats) begin
      n_cmp++; n_err++;
      $display("FAIL r_handshake: got %0d beats, required %0d", got, nbeats);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (resp !== '0) begin
      n_err++; $display("FAIL reset_resp_in_reset: got %h required 0", resp);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (resp !== '0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got resp=%h mem_req=%b required 0/0", resp, mem_req);
    end
  endtask

  task automatic test_write_incr();
    int hs;
    logic [3:0] bid;
    logic [1:0] brsp;
    wr_log.delete();
    addr_go(1'b1, 4'd5, 64'h100, 8'd3, 3'd3, 2'b01, hs);
    w_beats(64'hA0, 8'hFF, 4);
    b_collect(bid, brsp);
    n_cmp++;
    if (wr_log.size() !== 4) begin
      n_err++; $display("FAIL wr_incr_count: got %0d required 4", wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (wr_log[i] !== 10'(32'h20 + i) || sram[32'h20 + i] !== 64'hA0 + 64'(i)) begin
          n_err++;
          $display("FAIL wr_incr_beat%0d: got idx=%h data=%h required %h/%h", i, wr_log[i],
                   sram[32'h20 + i], 32'h20 + i, 64'hA0 + 64'(i));
        end
      end
    end
    n_cmp++;
    if (bid !== 4'd5 || brsp !== 2'b00) begin
      n_err++; $display("FAIL wr_incr_b: got id=%h resp=%b required 5/00", bid, brsp);
    end
  endtask

  task automatic test_read_incr();
    int hs;
    addr_go(1'b0, 4'd6, 64'h100, 8'd3, 3'd3, 2'b01, hs);
    r_collect(4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data[i] !== 64'hA0 + 64'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3) ||
          rd_id[i] !== 4'd6) begin
        n_err++;
        $display("FAIL rd_incr_beat%0d: got data=%h resp=%b last=%b id=%h required %h/00/%b/6",
                 i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], 64'hA0 + 64'(i), i == 3);
      end
    end
    n_cmp++;
    if (r_first_cyc - hs !== 2) begin
      n_err++; $display("FAIL rd_latency: got %0d required 2", r_first_cyc - hs);
    end
  endtask

  task automatic test_arbitration();
    int n;
    logic [3:0] bid;
    logic [1:0] brsp;
    do_reset();
    // First tie after reset: the read wins.
    req.ar = '0; req.ar.id = 4'd1; req.ar.addr = 64'h100; req.ar.size = 3'd3; req.ar.burst = 2'b01;
    req.aw = '0; req.aw.id = 4'd2; req.aw.addr = 64'h140; req.aw.size = 3'd3; req.aw.burst = 2'b01;
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    #1;
    n_cmp++;
    if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b0) begin
      n_err++; $display("FAIL arb_tie1: got ar/aw_ready=%b%b required 10", resp.ar_ready,
                        resp.aw_ready);
    end
    @(negedge clk);
    req.ar_valid = 1'b0;
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== 64'hA0 || rd_id[0] !== 4'd1) begin
      n_err++; $display("FAIL arb_read1: got %h/%h required a0/1", rd_data[0], rd_id[0]);
    end
    n = 0;
    while (resp.aw_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (resp.aw_ready !== 1'b1) begin
      n_err++; $display("FAIL arb_write_pending: got aw_ready=0 required 1");
    end
    @(negedge clk);
    req.aw_valid = 1'b0;
    w_beats(64'h55, 8'hFF, 1);
    b_collect(bid, brsp);
    n_cmp++;
    if (bid !== 4'd2 || brsp !== 2'b00) begin
      n_err++; $display("FAIL arb_write1_b: got %h/%b required 2/00", bid, brsp);
    end
    // Second tie: priority has rotated to the write.
    req.ar.id = 4'd4; req.ar.addr = 64'h140;
    req.aw.id = 4'd3; req.aw.addr = 64'h148;
    req.ar_valid = 1'b1;
    req.aw_valid = 1'b1;
    #1;
    n_cmp++;
    if (resp.ar_ready !== 1'b0 || resp.aw_ready !== 1'b1) begin
      n_err++; $display("FAIL arb_tie2: got ar/aw_ready=%b%b required 01", resp.ar_ready,
                        resp.aw_ready);
    end
    @(negedge clk);
    req.aw_valid = 1'b0;
    w_beats(64'h66, 8'hFF, 1);
    b_collect(bid, brsp);
    n_cmp++;
    if (bid !== 4'd3) begin
      n_err++; $display("FAIL arb_write2_b: got id=%h required 3", bid);
    end
    req.ar_valid = 1'b1;
    r_collect(1);
    req.ar_valid = 1'b0;
    n_cmp++;
    if (rd_data[0] !== 64'h55 || rd_id[0] !== 4'd4) begin
      n_err++; $display("FAIL arb_read2: got %h/%h required 55/4", rd_data[0], rd_id[0]);
    end
  endtask

  task automatic test_wrap();
    int hs;
    logic [9:0]  exp_idx[4];
    logic [63:0] exp_data[4];
    exp_idx  = '{10'h23, 10'h20, 10'h21, 10'h22};
    exp_data = '{64'hA3, 64'hA0, 64'hA1, 64'hA2};
    rd_log.delete();
    addr_go(1'b0, 4'd7, 64'h118, 8'd3, 3'd3, 2'b10, hs);
    r_collect(4);
    n_cmp++;
    if (rd_log.size() !== 4) begin
      n_err++; $display("FAIL wrap_count: got %0d required 4", rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rd_log[i] !== exp_idx[i] || rd_data[i] !== exp_data[i]) begin
          n_err++;
          $display("FAIL wrap_beat%0d: got idx=%h data=%h required %h/%h", i, rd_log[i],
                   rd_data[i], exp_idx[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int hs;
    int cnt0;
    logic [3:0] bid;
    logic [1:0] brsp;
    cnt0 = req_cnt;
    addr_go(1'b1, 4'd8, 64'h2000, 8'd0, 3'd3, 2'b01, hs);
    w_beats(64'h1234, 8'h0F, 1);
    b_collect(bid, brsp);
    n_cmp++;
    if (brsp !== 2'b10 || bid !== 4'd8 || req_cnt !== cnt0) begin
      n_err++; $display("FAIL oor_write: got resp=%b id=%h reqs=%0d required 10/8/0", brsp, bid,
                        req_cnt - cnt0);
    end
    addr_go(1'b0, 4'd9, 64'h2000, 8'd0, 3'd3, 2'b01, hs);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== 64'h0 || rd_resp[0] !== 2'b10 || rd_last[0] !== 1'b1 ||
        req_cnt !== cnt0) begin
      n_err++; $display("FAIL oor_read: got data=%h resp=%b last=%b reqs=%0d required 0/10/1/0",
                        rd_data[0], rd_resp[0], rd_last[0], req_cnt - cnt0);
    end
  endtask

  task automatic test_stall_reset();
    int hs;
    int n = 0;
    int cnt0;
    bit leak = 1'b0;
    addr_go(1'b0, 4'd10, 64'h100, 8'd7, 3'd3, 2'b01, hs);
    r_collect(2);
    n_cmp++;
    if (rd_data[0] !== 64'hA0 || rd_data[1] !== 64'hA1) begin
      n_err++; $display("FAIL stall_first_beats: got %h,%h required a0,a1", rd_data[0], rd_data[1]);
    end
    #1;
    while (resp.r_valid !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (resp.r_valid !== 1'b1 || resp.r.data !== 64'hA2 || resp.r.last !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got valid=%b data=%h required 1/a2", i,
                          resp.r_valid, resp.r.data);
      end
      @(negedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (resp !== '0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL stall_reset_async: got resp=%h mem_req=%b required 0/0", resp, mem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    cnt0 = req_cnt;
    req.r_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp !== '0 || mem_req !== 1'b0) leak = 1'b1;
      @(negedge clk);
    end
    req.r_ready = 1'b0;
    n_cmp++;
    if (leak || req_cnt !== cnt0) begin
      n_err++; $display("FAIL stall_no_pending: got leak=%b reqs=%0d required 0/0", leak,
                        req_cnt - cnt0);
    end
    addr_go(1'b0, 4'd11, 64'h108, 8'd0, 3'd3, 2'b01, hs);
    r_collect(1);
    n_cmp++;
    if (rd_data[0] !== 64'hA1 || rd_last[0] !== 1'b1 || rd_id[0] !== 4'd11) begin
      n_err++; $display("FAIL post_reset_read: got %h/%b/%h required a1/1/b", rd_data[0],
                        rd_last[0], rd_id[0]);
    end
  endtask

  initial begin
    req = '0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    test_reset();
    test_write_incr();
    test_read_incr();
    test_arbitration();
    test_wrap();
    test_out_of_range();
    test_stall_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
